// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the byte-wide generator/checker pair.
// Polynomial 0x04C11DB7, zero init, no final XOR; MSB of the register leaves first.
package crc32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam int          MIN_FRAME  = 5;

    // Byte-parallel next state: unrolls to the D8 XOR equations, d[i] meets crc[24+i].
    function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ d[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_strip_line.sv
// Four-deep byte delay line that holds back the trailing CRC bytes of a frame.
// Once full, every push pops the oldest byte so only payload ever leaves.
module crc32_strip_line (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_clear,
    input  logic [7:0] i_data,
    output logic       o_pop,
    output logic [7:0] o_data
);

    logic [7:0] r_line [4];
    logic [2:0] r_fill;
    logic       w_full;

    assign w_full = (r_fill == 3'd4);
    assign o_pop  = i_push & w_full;
    assign o_data = r_line[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_line[i] <= 8'h00;
            end
        end else if (i_clear) begin
            r_fill <= 3'd0;
        end else if (i_push) begin
            if (w_full) begin
                r_line[0] <= r_line[1];
                r_line[1] <= r_line[2];
                r_line[2] <= r_line[3];
                r_line[3] <= i_data;
            end else begin
                r_line[r_fill[1:0]] <= i_data;
                r_fill              <= r_fill + 3'd1;
            end
        end
    end

endmodule

// File: rtl/crc_32_parallel_check.sv
// CRC-32 receive checker: runs payload+CRC bytes through the D8 update, expects a
// zero residue, strips the 4 CRC bytes and reports one status per frame.
module crc_32_parallel_check
    import crc32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic       i_last,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_done,
    output logic       o_crc_ok,
    output logic       o_len_err,
    output logic       o_busy
);

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_crc;
    logic [CNT_W-1:0]  r_count;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic              r_out_last;
    logic              r_crc_ok;
    logic              r_len_err;

    logic              w_accept;
    logic              w_clear;
    logic [31:0]       w_crc_next;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_short;
    logic              w_pop;
    logic [7:0]        w_pop_data;

    assign w_accept     = i_valid & o_ready;
    assign w_clear      = (r_state == DONE);
    assign w_crc_next   = crc32_d8_next(r_crc, i_data);
    assign w_count_next = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
    assign w_short      = (w_count_next < CNT_W'(MIN_FRAME));

    crc32_strip_line u_strip (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_clear (w_clear),
        .i_data  (i_data),
        .o_pop   (w_pop),
        .o_data  (w_pop_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, RECV: begin
                if (w_accept) begin
                    w_next_state = i_last ? DONE : RECV;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state != DONE);
        o_busy  = (r_state != IDLE);
        o_done  = (r_state == DONE);
    end

    // Status is captured with the in_last byte so it appears together with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc       <= 32'h0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_out_valid <= w_pop;
            r_out_last  <= w_pop & i_last & ~w_short;
            if (w_pop) begin
                r_out_data <= w_pop_data;
            end
            if (w_clear) begin
                r_crc   <= 32'h0;
                r_count <= '0;
            end else if (w_accept) begin
                r_crc   <= w_crc_next;
                r_count <= w_count_next;
                if (i_last) begin
                    r_crc_ok  <= (w_crc_next == 32'h0) & ~w_short;
                    r_len_err <= w_short;
                end
            end
        end
    end

    assign o_valid   = r_out_valid;
    assign o_data    = r_out_data;
    assign o_last    = r_out_last;
    assign o_crc_ok  = r_crc_ok;
    assign o_len_err = r_len_err;

endmodule

// File: tb/tb_crc_32_parallel_check.sv
// Directed bench for crc_32_parallel_check: table of frames with expected payload and
// status, plus back-to-back, idle-gap and mid-frame reset sequences.
module tb_crc_32_parallel_check;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iValid = 1'b0;
    logic       iLast = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oReady, oValid, oLast, oDone, oCrcOk, oLenErr, oBusy;
    logic [7:0] oData;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              len;
        logic [15:0][7:0] data;
        bit              expOk;
        bit              expLenErr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } rx_t;

    vec_t       vecs [6];
    rx_t        rxQ [$];
    logic [1:0] statQ [$];

    crc_32_parallel_check #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (iValid),
        .i_last    (iLast),
        .i_data    (iData),
        .o_ready   (oReady),
        .o_valid   (oValid),
        .o_data    (oData),
        .o_last    (oLast),
        .o_done    (oDone),
        .o_crc_ok  (oCrcOk),
        .o_len_err (oLenErr),
        .o_busy    (oBusy)
    );

    always #5 clk = ~clk;

    // Outputs are registered, so the falling edge sees a stable value for the last rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (oValid) rxQ.push_back('{oData, oLast});
            if (oDone) statQ.push_back({oCrcOk, oLenErr});
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Generator model in augmented long-division form: message followed by 32 zero bits.
    function automatic logic [31:0] genCrc(input logic [15:0][7:0] d, input int n);
        logic [31:0] r;
        logic [7:0]  b;
        logic        top;
        r = 32'h0;
        for (int k = 0; k < n + 4; k++) begin
            b = (k < n) ? d[k] : 8'h00;
            for (int j = 7; j >= 0; j--) begin
                top = r[31];
                r   = {r[30:0], b[j]};
                if (top) r = r ^ 32'h04C11DB7;
            end
        end
        return r;
    endfunction

    task automatic appendCrc(input int idx, input int n);
        logic [31:0] c;
        c = genCrc(vecs[idx].data, n);
        vecs[idx].data[n]   = c[31:24];
        vecs[idx].data[n+1] = c[23:16];
        vecs[idx].data[n+2] = c[15:8];
        vecs[idx].data[n+3] = c[7:0];
        vecs[idx].len       = n + 4;
    endtask

    task automatic applyStimulus(input int idx, input bit gaps, input int nBytes, output int firstWait);
        int waits;
        firstWait = 0;
        for (int i = 0; i < nBytes; i++) begin
            @(negedge clk);
            if (gaps && i > 0) begin
                iValid = 1'b0;
                iLast  = 1'b0;
                @(negedge clk);
            end
            iValid = 1'b1;
            iData  = vecs[idx].data[i];
            iLast  = (i == vecs[idx].len - 1);
            waits  = 0;
            while (!oReady && waits < 20) begin
                @(negedge clk);
                waits++;
            end
            if (waits >= 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL readyTimeout got ready=0 expected ready=1 (frame %0d byte %0d)", idx, i);
                return;
            end
            if (i == 0) firstWait = waits;
        end
    endtask

    task automatic idleBus();
        @(negedge clk);
        iValid = 1'b0;
        iLast  = 1'b0;
    endtask

    task automatic checkOutput(input int idx);
        int  n;
        int  waits;
        rx_t rx;
        logic [1:0] st;
        waits = 0;
        while (statQ.size() == 0 && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (statQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout frame %0d got no done expected done", idx);
            return;
        end
        n = vecs[idx].expLenErr ? 0 : vecs[idx].len - 4;
        for (int k = 0; k < n; k++) begin
            if (rxQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL payloadMissing frame %0d byte %0d got none expected 0x%0h", idx, k, vecs[idx].data[k]);
            end else begin
                rx = rxQ.pop_front();
                check($sformatf("payload[%0d][%0d]", idx, k), int'(rx.data), int'(vecs[idx].data[k]));
                check($sformatf("outLast[%0d][%0d]", idx, k), int'(rx.last), (k == n - 1) ? 1 : 0);
            end
        end
        st = statQ.pop_front();
        check($sformatf("crcOk[%0d]", idx), int'(st[1]), int'(vecs[idx].expOk));
        check($sformatf("lenErr[%0d]", idx), int'(st[0]), int'(vecs[idx].expLenErr));
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, ".ready"},  int'(oReady),  1);
        check({tag, ".valid"},  int'(oValid),  0);
        check({tag, ".data"},   int'(oData),   0);
        check({tag, ".last"},   int'(oLast),   0);
        check({tag, ".done"},   int'(oDone),   0);
        check({tag, ".crcOk"},  int'(oCrcOk),  0);
        check({tag, ".lenErr"}, int'(oLenErr), 0);
        check({tag, ".busy"},   int'(oBusy),   0);
    endtask

    initial begin
        int w;

        for (int v = 0; v < 6; v++) vecs[v].data = '0;
        // 0: all zeros, CRC of zeros is zero
        vecs[0].len = 5;  vecs[0].expOk = 1'b1; vecs[0].expLenErr = 1'b0;
        // 1: golden "123456789" plus generator CRC
        for (int i = 0; i < 9; i++) vecs[1].data[i] = 8'h31 + 8'(i);
        appendCrc(1, 9);  vecs[1].expOk = 1'b1; vecs[1].expLenErr = 1'b0;
        // 2: corrupted CRC on a single zero payload byte
        vecs[2].data[4] = 8'h01;
        vecs[2].len = 5;  vecs[2].expOk = 1'b0; vecs[2].expLenErr = 1'b0;
        // 3: short frame
        vecs[3].data[0] = 8'hAA; vecs[3].data[1] = 8'hBB; vecs[3].data[2] = 8'hCC;
        vecs[3].len = 3;  vecs[3].expOk = 1'b0; vecs[3].expLenErr = 1'b1;
        // 4: single byte frame
        vecs[4].data[0] = 8'h5A;
        vecs[4].len = 1;  vecs[4].expOk = 1'b0; vecs[4].expLenErr = 1'b1;
        // 5: second good frame, 5 payload bytes
        vecs[5].data[0] = 8'hDE; vecs[5].data[1] = 8'hAD; vecs[5].data[2] = 8'hBE;
        vecs[5].data[3] = 8'hEF; vecs[5].data[4] = 8'h42;
        appendCrc(5, 5);  vecs[5].expOk = 1'b1; vecs[5].expLenErr = 1'b0;

        repeat (3) @(negedge clk);
        checkResetValues("resetHeld");
        rst_n = 1'b1;
        @(negedge clk);
        checkResetValues("afterReset");

        for (int idx = 0; idx < 6; idx++) begin
            applyStimulus(idx, 1'b0, vecs[idx].len, w);
            idleBus();
            checkOutput(idx);
        end

        $display("[TB] golden frame with idle gaps");
        applyStimulus(1, 1'b1, vecs[1].len, w);
        idleBus();
        checkOutput(1);

        $display("[TB] back-to-back frames");
        applyStimulus(2, 1'b0, vecs[2].len, w);
        applyStimulus(5, 1'b0, vecs[5].len, w);
        check("b2bReadyLowA", w, 1);
        applyStimulus(3, 1'b0, vecs[3].len, w);
        check("b2bReadyLowB", w, 1);
        applyStimulus(1, 1'b1, vecs[1].len, w);
        check("b2bReadyLowC", w, 1);
        idleBus();
        checkOutput(2);
        checkOutput(5);
        checkOutput(3);
        checkOutput(1);

        $display("[TB] reset mid-frame");
        applyStimulus(5, 1'b0, 3, w);
        @(negedge clk);
        check("midFrameBusy", int'(oBusy), 1);
        iValid = 1'b0;
        iLast  = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkResetValues("midReset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("noDoneAfterReset", statQ.size(), 0);
        check("noPayloadAfterReset", rxQ.size(), 0);
        applyStimulus(1, 1'b0, vecs[1].len, w);
        idleBus();
        checkOutput(1);

        repeat (3) @(negedge clk);
        #1;
        check("leftoverPayload", rxQ.size(), 0);
        check("leftoverStatus", statQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
